// File: rtl/irq_latch16_if.sv
// Request/handshake bundle for the 16-line interrupt latch.
// The slave side is the latch itself; the master side is the requester/consumer.
interface irq_latch16_if;
    logic [15:0] req;
    logic [15:0] mask;
    logic        en;
    logic        ovr_clr;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [15:0] pend;
    logic [15:0] ovr;
    logic        any;

    modport slave (
        input  req, mask, en, ovr_clr, out_ready,
        output out_valid, out_idx, pend, ovr, any
    );

    modport master (
        output req, mask, en, ovr_clr, out_ready,
        input  out_valid, out_idx, pend, ovr, any
    );
endinterface

// File: rtl/irq_latch16.sv
// 16-line rising-edge interrupt latch with fixed priority (bit 0 highest),
// per-line masking, sticky overrun flags and a valid/ready index output.
module irq_latch16 (
    input  logic          clk,
    input  logic          rst,
    irq_latch16_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    // Number of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                r = 4'(i);
            end
        end
        return r;
    endfunction

    // One-hot decode of a 4-bit line number.
    function automatic logic [15:0] one_hot(input logic [3:0] idx);
        return 16'd1 << idx;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] req_q, req_d;
    logic [15:0] pend_q, pend_d;
    logic [15:0] ovr_q, ovr_d;
    logic [3:0]  idx_q, idx_d;

    logic [15:0] rise_s;
    logic [15:0] clr_vec_s;
    logic [15:0] eligible_s;
    logic        accept_s;
    logic        out_valid_s;

    // State and data registers; reset holds req_q high so lines high at release give no event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 16'hFFFF;
            pend_q  <= 16'h0000;
            ovr_q   <= 16'h0000;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            idx_q   <= idx_d;
        end
    end

    // Edge detect, pending/overrun update; a new rise always beats a clear.
    always_comb begin
        req_d      = bus.req;
        rise_s     = bus.req & ~req_q;
        eligible_s = pend_q & ~bus.mask;
        accept_s   = (state_q == ST_OFFER) && bus.out_ready;
        if (accept_s) begin
            clr_vec_s = one_hot(idx_q);
        end else begin
            clr_vec_s = 16'h0000;
        end
        pend_d = (pend_q & ~clr_vec_s) | rise_s;
        if (bus.ovr_clr) begin
            ovr_d = rise_s & pend_q & ~clr_vec_s;
        end else begin
            ovr_d = ovr_q | (rise_s & pend_q & ~clr_vec_s);
        end
    end

    // Next-state logic; selection looks only at the registered pending vector.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.en && (eligible_s != 16'h0000)) begin
                    idx_d   = lowest_set(eligible_s);
                    state_d = ST_OFFER;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_OFFER: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OFFER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode; the offer is held steady until accepted.
    always_comb begin
        case (state_q)
            ST_OFFER: out_valid_s = 1'b1;
            ST_IDLE:  out_valid_s = 1'b0;
            default:  out_valid_s = 1'b0;
        endcase
    end

    assign bus.out_valid = out_valid_s;
    assign bus.out_idx   = idx_q;
    assign bus.pend      = pend_q;
    assign bus.ovr       = ovr_q;
    assign bus.any       = |eligible_s;

endmodule

// File: tb/tb_irq_latch16.sv
// Directed bench for irq_latch16: expected accepted indices go into a queue,
// a negedge monitor checks every handshake and the idle gap after it.
module tb_irq_latch16;

    logic clk;
    logic rst;
    irq_latch16_if bus ();

    irq_latch16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];
    logic gap_chk = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted handshake must match the next queued index,
    // and the cycle after an acceptance must not offer.
    always @(negedge clk) begin
        logic [3:0] e;
        if (rst) begin
            gap_chk = 1'b0;
        end else begin
            if (gap_chk) begin
                gap_chk = 1'b0;
                chk("idle_gap", {15'd0, bus.out_valid}, 16'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", {12'd0, bus.out_idx}, 16'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("accept_idx", {12'd0, bus.out_idx}, {12'd0, e});
                end
                gap_chk = 1'b1;
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.req = 16'h0000;
        bus.mask = 16'h0000;
        bus.en = 1'b1;
        bus.ovr_clr = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("rst_idx", {12'd0, bus.out_idx}, 16'd0);
        chk("rst_pend", bus.pend, 16'h0000);
        chk("rst_ovr", bus.ovr, 16'h0000);
        tick();
        rst = 1'b0;
        tick(); tick();

        // Single event on line 5: offered two edges after the rise.
        bus.req = 16'h0020;
        exp_q.push_back(4'd5);
        tick();
        chk("single_pend", bus.pend, 16'h0020);
        chk("single_nvalid", {15'd0, bus.out_valid}, 16'd0);
        tick();
        chk("single_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("single_idx", {12'd0, bus.out_idx}, 16'd5);
        tick();
        chk("single_clr", bus.pend, 16'h0000);
        bus.req = 16'h0000;
        tick(); tick();

        // Priority: lines 9 and 2 together -> 2 then 9.
        bus.req = 16'h0204;
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd9);
        tick();
        chk("prio_pend", bus.pend, 16'h0204);
        tick(); tick();
        chk("prio_after2", bus.pend, 16'h0200);
        tick(); tick(); tick();
        chk("prio_done", bus.pend, 16'h0000);
        bus.req = 16'h0000;
        tick(); tick();

        // Backpressure on line 7, then line 1 arrives as 7 is accepted.
        bus.out_ready = 1'b0;
        bus.req = 16'h0080;
        exp_q.push_back(4'd7);
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {15'd0, bus.out_valid}, 16'd1);
            chk("bp_idx", {12'd0, bus.out_idx}, 16'd7);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.req = 16'h0082;
        exp_q.push_back(4'd1);
        tick();
        chk("bp_pend1", bus.pend, 16'h0002);
        tick(); tick(); tick();
        chk("bp_done", bus.pend, 16'h0000);
        bus.req = 16'h0000;
        tick(); tick();

        // Masked line 3 stays pending, is offered one cycle after unmask.
        bus.mask = 16'h0008;
        bus.req = 16'h0008;
        tick();
        chk("mask_pend", bus.pend, 16'h0008);
        chk("mask_any", {15'd0, bus.any}, 16'd0);
        tick(); tick();
        chk("mask_nvalid", {15'd0, bus.out_valid}, 16'd0);
        bus.mask = 16'h0000;
        exp_q.push_back(4'd3);
        #1;
        chk("unmask_any", {15'd0, bus.any}, 16'd1);
        tick();
        chk("unmask_valid", {15'd0, bus.out_valid}, 16'd1);
        chk("unmask_idx", {12'd0, bus.out_idx}, 16'd3);
        tick(); tick();
        chk("unmask_done", bus.pend, 16'h0000);

        // Disabled selection on line 6.
        bus.en = 1'b0;
        bus.req = 16'h0048;
        tick(); tick(); tick();
        chk("en0_nvalid", {15'd0, bus.out_valid}, 16'd0);
        chk("en0_pend", bus.pend, 16'h0040);
        chk("en0_any", {15'd0, bus.any}, 16'd1);
        bus.en = 1'b1;
        exp_q.push_back(4'd6);
        tick();
        chk("en1_idx", {12'd0, bus.out_idx}, 16'd6);
        tick(); tick();
        bus.req = 16'h0000;
        tick();

        // Overrun on line 4, clear, then a rise in the acceptance cycle.
        bus.out_ready = 1'b0;
        bus.req = 16'h0010;
        exp_q.push_back(4'd4);
        tick();
        bus.req = 16'h0000;
        tick();
        bus.req = 16'h0010;
        tick();
        chk("ovr_set", bus.ovr, 16'h0010);
        tick();
        chk("ovr_sticky", bus.ovr, 16'h0010);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        chk("ovr_clr", bus.ovr, 16'h0000);
        bus.req = 16'h0000;
        tick();
        chk("ovr_offer", {12'd0, bus.out_idx}, 16'd4);
        bus.req = 16'h0010;
        bus.out_ready = 1'b1;
        exp_q.push_back(4'd4);
        tick();
        chk("setwins_pend", bus.pend, 16'h0010);
        chk("setwins_novr", bus.ovr, 16'h0000);
        tick(); tick(); tick();
        chk("setwins_done", bus.pend, 16'h0000);
        bus.req = 16'h0000;
        tick();

        // Line 0 held high through reset produces no event.
        bus.req = 16'h0001;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("held_nvalid", {15'd0, bus.out_valid}, 16'd0);
        end
        chk("held_pend", bus.pend, 16'h0000);
        bus.req = 16'h0000;
        tick();

        // Reset during an offer discards it.
        bus.out_ready = 1'b0;
        bus.req = 16'h0004;
        tick(); tick();
        chk("abort_pre", {15'd0, bus.out_valid}, 16'd1);
        rst = 1'b1;
        tick();
        chk("abort_valid", {15'd0, bus.out_valid}, 16'd0);
        chk("abort_pend", bus.pend, 16'h0000);
        rst = 1'b0;
        tick(); tick(); tick();
        chk("abort_after", {15'd0, bus.out_valid}, 16'd0);

        chk("queue_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
